flip_scheduler: RTL
===================

# flip_scheduler

Sequences one WalkSAT flip decision per unsatisfied clause through the `Heuristic_Selector` datapath. It accepts an NSAT-literal clause, fetches each literal's break value from the break-value unit, and streams the values to the selector on consecutive cycles. It then captures the chosen literal and hands the variable index to the flip unit. It also counts flips against a max-flips budget. It sits between the clause picker and the flip/assignment unit; the parent instantiates the selector beside it.

## Interface
Parameters:
- `NSAT`, 3: literals per clause (fixed 3 in this revision)
- `NSAT_BITS`, 2: width of literal index
- `MAX_CLAUSES_PER_VARIABLE_BITS`, 5: break-value width
- `VAR_BITS`, 10: variable-index width
- `FLIP_BITS`, 32: flip-counter width

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `restart_i`  in  1  synchronous clear of counter/timeout/state; highest priority after reset
- `max_flips_i`  in  FLIP_BITS  flip budget; 0 = unlimited
- `clause_valid_i`  in  1  clause offered
- `clause_vars_i`  in  NSAT*VAR_BITS  variable indices, literal 0 in LSBs
- `clause_ready_o`  out  1  high only in IDLE with timeout_o low
- `bv_req_o`  out  1  break-value request
- `bv_var_o`  out  VAR_BITS  variable being requested
- `bv_valid_i`  in  1  break value returned (may be same cycle as request)
- `bv_i`  in  MAX_CLAUSES_PER_VARIABLE_BITS  break value
- `random_i`  in  32  from `lfsr_prng`
- `hs_current_flip_o`  out  NSAT_BITS  to selector `current_flip_i`
- `hs_break_value_o`  out  MAX_CLAUSES_PER_VARIABLE_BITS  to selector `break_value_i`
- `hs_random_o`  out  32  to selector `random_i`
- `hs_selected_flip_i`  in  NSAT_BITS  from selector
- `hs_random_selection_i`  in  1  from selector
- `flip_valid_o`  out  1  flip decision offered
- `flip_var_o`  out  VAR_BITS  variable to flip
- `flip_random_o`  out  1  decision came from random walk
- `flip_ready_i`  in  1  flip unit accepts
- `flip_count_o`  out  FLIP_BITS  completed flips
- `timeout_o`  out  1  sticky: budget exhausted

## Operation
- States: IDLE, FETCH0, FETCH1, FETCH2, FEED0, FEED1, FEED2, CAPTURE, ISSUE.
- IDLE: on `clause_valid_i & clause_ready_o`, register all three vars and go to FETCH0.
- FETCHj: drive `bv_req_o`=1 and `bv_var_o`=var[j]. On `bv_valid_i`, store `bv_i` into bv[j] and advance. `bv_valid_i` outside FETCH is ignored.
- FEEDj: drive `hs_current_flip_o`=j and `hs_break_value_o`=bv[j].
  - FEED2 also drives `hs_random_o`=random_i; `random_i` is sampled in that cycle and held in a register.
  - In all other states `hs_random_o`=0, `hs_current_flip_o`=0, `hs_break_value_o`=0.
- CAPTURE: register `flip_var_o`=var[hs_selected_flip_i] and `flip_random_o`=hs_random_selection_i.
  - An out-of-range select value (3) maps to var[0].
- ISSUE: `flip_valid_o`=1. Var and random bit stay stable until `flip_ready_i`.
- On the ISSUE handshake:
  - `flip_count_o` increments (saturating at all-ones).
  - If `max_flips_i`≠0 and the new count ≥ `max_flips_i`, set `timeout_o`.
  - Return to IDLE.
- Duplicate variable indices within a clause are legal; no special handling.
- `restart_i`: next state IDLE, counter 0, timeout 0, all handshakes dropped. Any in-flight clause is discarded with no flip issued.

## Timing
- Reset values: state IDLE, `clause_ready_o`=1. All other outputs 0, including `flip_count_o`, `timeout_o` and all hs_* outputs.
- `clause_ready_o` is combinational from state and `timeout_o`.
- Minimum latency, with same-cycle bv responses and no backpressure:
  - accept edge at cycle 0
  - FETCH0–2 in cycles 1–3
  - FEED0–2 in cycles 4–6
  - CAPTURE in cycle 7 (selector output registered at end of cycle 6)
  - `flip_valid_o` high in cycle 8
- Each bv stall cycle adds one cycle of latency. FEED0–2 are never split; the selector always sees three back-to-back cycles.
- Budget exhaustion: `timeout_o` rises the cycle after the final flip handshake, and `clause_ready_o` stays 0 thereafter.
- Changing `max_flips_i` mid-run takes effect at the next handshake compare.

## Structure
- Shared `sat_pkg` holds:
  - state enum
  - NSAT, NSAT_BITS, MAX_CLAUSES_PER_VARIABLE_BITS and VAR_BITS defaults, shared with `Heuristic_Selector`
- One natural sub-module: `flip_budget_counter` (saturating count, compare, sticky timeout, restart clear). FSM and operand registers stay in the top.

## Test plan
- Vars (5,9,12), bv 3,0,4 returned same-cycle; stub selector returns 1.
  - hs_* shows (0,3),(1,0),(2,4) in cycles 4–6.
  - `flip_var_o`=9 with `flip_valid_o` in cycle 8.
- bv_valid_i delayed 2 cycles for literal 1 → FETCH1 lasts 3 cycles; FEED still 3 contiguous cycles; flip valid in cycle 10.
- `flip_ready_i` low 4 cycles in ISSUE → `flip_var_o`/`flip_random_o` stable; `clause_ready_o`=0; count increments exactly once.
- `max_flips_i`=2, three clauses offered → count 1 then 2; `timeout_o`=1 after second handshake; third clause never accepted.
- `restart_i` pulsed in FETCH1 → IDLE next cycle; `bv_req_o`=0; no flip issued; count 0; next clause completes normally.
- `reset` asserted mid-FEED1 → all outputs 0 immediately (asynchronous), `clause_ready_o`=1.

Source files
------------

// File: rtl/sat_pkg.sv
// ---------------------------------------------------------------------------
// sat_pkg
// Shared definitions for the WalkSAT datapath (flip_scheduler and
// Heuristic_Selector).
//   NSAT                          literals per clause
//   NSAT_BITS                     width of a literal index
//   MAX_CLAUSES_PER_VARIABLE_BITS width of a break value
//   VAR_BITS                      width of a variable index
//   sched_state_e                 flip_scheduler sequencing states
// ---------------------------------------------------------------------------
package sat_pkg;

    localparam int NSAT                          = 3;
    localparam int NSAT_BITS                     = 2;
    localparam int MAX_CLAUSES_PER_VARIABLE_BITS = 5;
    localparam int VAR_BITS                      = 10;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH0  = 4'd1,
        ST_FETCH1  = 4'd2,
        ST_FETCH2  = 4'd3,
        ST_FEED0   = 4'd4,
        ST_FEED1   = 4'd5,
        ST_FEED2   = 4'd6,
        ST_CAPTURE = 4'd7,
        ST_ISSUE   = 4'd8
    } sched_state_e;

endpackage

// File: rtl/flip_budget_counter.sv
// ---------------------------------------------------------------------------
// flip_budget_counter
// Counts completed flips (saturating) and raises a sticky timeout once the
// count reaches a non-zero budget.
//   clk, reset     clock / asynchronous active-high reset
//   restart_i      synchronous clear of count and timeout (beats inc_i)
//   inc_i          one completed flip this cycle
//   max_flips_i    budget, 0 = unlimited; compared on every increment
//   count_o        completed flips
//   timeout_o      sticky budget-exhausted flag
// ---------------------------------------------------------------------------
module flip_budget_counter #(
    parameter int FLIP_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restart_i,
    input  logic                 inc_i,
    input  logic [FLIP_BITS-1:0] max_flips_i,
    output logic [FLIP_BITS-1:0] count_o,
    output logic                 timeout_o
);

    logic [FLIP_BITS-1:0] count_reg, count_next;
    logic                 timeout_reg, timeout_next;

    always_comb begin
        count_next   = count_reg;
        timeout_next = timeout_reg;
        if (restart_i) begin
            count_next   = '0;
            timeout_next = 1'b0;
        end else if (inc_i) begin
            // Saturate rather than wrap so a huge run never looks fresh.
            if (count_reg != '1) begin
                count_next = count_reg + 1'b1;
            end
            // The compare uses the post-increment value, so the flag rises
            // together with the count that reached the budget.
            if ((max_flips_i != '0) && (count_next >= max_flips_i)) begin
                timeout_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            count_reg   <= count_next;
            timeout_reg <= timeout_next;
        end
    end

    assign count_o   = count_reg;
    assign timeout_o = timeout_reg;

endmodule

// File: rtl/flip_scheduler.sv
// ---------------------------------------------------------------------------
// flip_scheduler
// Sequences one WalkSAT flip decision per unsatisfied clause: fetches the
// break value of each literal, streams them to the Heuristic_Selector on
// three back-to-back cycles, captures the selected literal and offers the
// variable to the flip unit. Completed flips are counted against a budget.
//   clk, reset             clock / asynchronous active-high reset
//   restart_i              synchronous abort + counter/timeout clear
//   max_flips_i            flip budget (0 = unlimited)
//   clause_*               clause input handshake (literal 0 in LSBs)
//   bv_*                   break-value unit request/response
//   random_i               PRNG word forwarded to the selector
//   hs_*                   selector feed and selector result
//   flip_*                 flip decision handshake to the flip unit
//   flip_count_o           completed flips
//   timeout_o              sticky budget-exhausted flag
// ---------------------------------------------------------------------------
module flip_scheduler #(
    parameter int NSAT                          = sat_pkg::NSAT,
    parameter int NSAT_BITS                     = sat_pkg::NSAT_BITS,
    parameter int MAX_CLAUSES_PER_VARIABLE_BITS = sat_pkg::MAX_CLAUSES_PER_VARIABLE_BITS,
    parameter int VAR_BITS                      = sat_pkg::VAR_BITS,
    parameter int FLIP_BITS                     = 32
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     restart_i,
    input  logic [FLIP_BITS-1:0]                     max_flips_i,
    input  logic                                     clause_valid_i,
    input  logic [NSAT*VAR_BITS-1:0]                 clause_vars_i,
    output logic                                     clause_ready_o,
    output logic                                     bv_req_o,
    output logic [VAR_BITS-1:0]                      bv_var_o,
    input  logic                                     bv_valid_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] bv_i,
    input  logic [31:0]                              random_i,
    output logic [NSAT_BITS-1:0]                     hs_current_flip_o,
    output logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] hs_break_value_o,
    output logic [31:0]                              hs_random_o,
    input  logic [NSAT_BITS-1:0]                     hs_selected_flip_i,
    input  logic                                     hs_random_selection_i,
    output logic                                     flip_valid_o,
    output logic [VAR_BITS-1:0]                      flip_var_o,
    output logic                                     flip_random_o,
    input  logic                                     flip_ready_i,
    output logic [FLIP_BITS-1:0]                     flip_count_o,
    output logic                                     timeout_o
);

    import sat_pkg::*;

    sched_state_e state_reg, state_next;

    logic [VAR_BITS-1:0]                      clause_var [NSAT];
    logic [VAR_BITS-1:0]                      var_reg    [NSAT];
    logic [MAX_CLAUSES_PER_VARIABLE_BITS-1:0] bv_reg     [NSAT];

    logic                 fetch_active, feed_active;
    logic [NSAT_BITS-1:0] fetch_idx, feed_idx;
    logic                 clause_fire, flip_fire;
    logic [VAR_BITS-1:0]  selected_var;
    logic [VAR_BITS-1:0]  flip_var_reg;
    logic                 flip_random_reg;

    assign clause_ready_o = (state_reg == ST_IDLE) && !timeout_o;
    assign clause_fire    = clause_valid_i && clause_ready_o && !restart_i;
    assign flip_valid_o   = (state_reg == ST_ISSUE);
    assign flip_fire      = flip_valid_o && flip_ready_i;

    // Decode which literal (if any) is being fetched or fed this cycle.
    always_comb begin
        fetch_active = 1'b0;
        fetch_idx    = '0;
        feed_active  = 1'b0;
        feed_idx     = '0;
        case (state_reg)
            ST_FETCH0: begin fetch_active = 1'b1; fetch_idx = NSAT_BITS'(0); end
            ST_FETCH1: begin fetch_active = 1'b1; fetch_idx = NSAT_BITS'(1); end
            ST_FETCH2: begin fetch_active = 1'b1; fetch_idx = NSAT_BITS'(2); end
            ST_FEED0:  begin feed_active  = 1'b1; feed_idx  = NSAT_BITS'(0); end
            ST_FEED1:  begin feed_active  = 1'b1; feed_idx  = NSAT_BITS'(1); end
            ST_FEED2:  begin feed_active  = 1'b1; feed_idx  = NSAT_BITS'(2); end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (restart_i) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:    if (clause_fire) state_next = ST_FETCH0;
                ST_FETCH0:  if (bv_valid_i)  state_next = ST_FETCH1;
                ST_FETCH1:  if (bv_valid_i)  state_next = ST_FETCH2;
                ST_FETCH2:  if (bv_valid_i)  state_next = ST_FEED0;
                // The feed phase never stalls: the selector expects three
                // consecutive literals.
                ST_FEED0:   state_next = ST_FEED1;
                ST_FEED1:   state_next = ST_FEED2;
                ST_FEED2:   state_next = ST_CAPTURE;
                ST_CAPTURE: state_next = ST_ISSUE;
                ST_ISSUE:   if (flip_ready_i) state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Per-literal operand registers: variable index loaded on accept, break
    // value loaded when its own fetch completes.
    genvar gi;
    generate
        for (gi = 0; gi < NSAT; gi++) begin : g_literal
            assign clause_var[gi] = clause_vars_i[gi*VAR_BITS +: VAR_BITS];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    var_reg[gi] <= '0;
                end else if (clause_fire) begin
                    var_reg[gi] <= clause_var[gi];
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    bv_reg[gi] <= '0;
                end else if (!restart_i && fetch_active && bv_valid_i &&
                             (fetch_idx == NSAT_BITS'(gi))) begin
                    bv_reg[gi] <= bv_i;
                end
            end
        end
    endgenerate

    assign bv_req_o          = fetch_active;
    assign bv_var_o          = fetch_active ? var_reg[fetch_idx] : '0;
    assign hs_current_flip_o = feed_idx;
    assign hs_break_value_o  = feed_active ? bv_reg[feed_idx] : '0;
    // The selector latches the random word itself during the last feed cycle.
    assign hs_random_o       = (state_reg == ST_FEED2) ? random_i : 32'd0;

    // A select value beyond the last literal falls back to literal 0.
    assign selected_var = (hs_selected_flip_i < NSAT_BITS'(NSAT)) ?
                          var_reg[hs_selected_flip_i] : var_reg[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flip_var_reg    <= '0;
            flip_random_reg <= 1'b0;
        end else if (restart_i) begin
            flip_var_reg    <= '0;
            flip_random_reg <= 1'b0;
        end else if (state_reg == ST_CAPTURE) begin
            flip_var_reg    <= selected_var;
            flip_random_reg <= hs_random_selection_i;
        end
    end

    assign flip_var_o    = flip_var_reg;
    assign flip_random_o = flip_random_reg;

    flip_budget_counter #(
        .FLIP_BITS (FLIP_BITS)
    ) u_budget (
        .clk         (clk),
        .reset       (reset),
        .restart_i   (restart_i),
        .inc_i       (flip_fire),
        .max_flips_i (max_flips_i),
        .count_o     (flip_count_o),
        .timeout_o   (timeout_o)
    );

endmodule
